// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, counter sizing
// and a legality check for the parameter set.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        SYNC,
        HOLD,
        RELEASE,
        RUN,
        SW_HOLD
    } state_e;

    // Width needed so a single counter can reach the longest in-state count
    // without wrapping.
    function automatic int cnt_width(input int hold_cycles,
                                     input int sw_hold_cycles,
                                     input int num_out,
                                     input int stagger);
        int longest;
        longest = hold_cycles;
        if (sw_hold_cycles > longest) begin
            longest = sw_hold_cycles;
        end
        if ((num_out - 1) * stagger > longest) begin
            longest = (num_out - 1) * stagger;
        end
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

    // True when every parameter sits inside its legal range.
    function automatic bit params_legal(input int sync_stages,
                                        input int hold_cycles,
                                        input int num_out,
                                        input int stagger,
                                        input int sw_hold_cycles);
        return (sync_stages >= 2) && (hold_cycles >= 1) && (num_out >= 1) &&
               (stagger >= 1) && (sw_hold_cycles >= 1);
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Reset deassertion synchronizer: clears instantly on rst and lets a constant
// 1 ripple through STAGES flops so the release is aligned to clk.
module reset_sync_chain
    import reset_seq_pkg::*;
#(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    output logic sync_o
);

    logic [STAGES-1:0] chain_q;

    // Shift a constant 1 toward the output; rst empties the whole chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], 1'b1};
        end
    end

    assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset network generator: synchronizes the raw reset release, stretches it,
// then releases NUM_OUT domains on a fixed stagger. A software request in RUN
// re-asserts every domain and replays the release, acknowledged with sw_ack.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int NUM_OUT        = 4,
    parameter int STAGGER        = 2,
    parameter int SW_HOLD_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_req,
    output logic               sw_ack,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               ready
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, SW_HOLD_CYCLES, NUM_OUT, STAGGER);

    // HOLD is entered one edge later than SW_HOLD relative to its trigger,
    // so it stops one count earlier to keep the documented timelines.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'((NUM_OUT - 1) * STAGGER);

    if (!params_legal(SYNC_STAGES, HOLD_CYCLES, NUM_OUT, STAGGER, SW_HOLD_CYCLES)) begin : g_param_check
        $error("reset_sequencer: parameter set out of legal range");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
    logic               ready_q, ready_d;
    logic               sw_ack_q, sw_ack_d;
    logic               sw_active_q, sw_active_d;
    logic               sync_out;

    reset_sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .sync_o(sync_out)
    );

    // Domains whose release step has been reached by the given step.
    function automatic logic [NUM_OUT-1:0] released_mask(input logic [CNT_W-1:0] step);
        logic [NUM_OUT-1:0] mask;
        mask = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            mask[i] = (i * STAGGER <= int'(step));
        end
        return mask;
    endfunction

    // State, counter and output flops; rst forces the full reset picture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SYNC;
            cnt_q       <= '0;
            rst_out_q   <= '1;
            ready_q     <= 1'b0;
            sw_ack_q    <= 1'b0;
            sw_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_out_q   <= rst_out_d;
            ready_q     <= ready_d;
            sw_ack_q    <= sw_ack_d;
            sw_active_q <= sw_active_d;
        end
    end

    // Sequencing: releases only ever clear bits, so each domain drops once.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_out_d   = rst_out_q;
        ready_d     = ready_q;
        sw_ack_d    = 1'b0;
        sw_active_d = sw_active_q;
        case (state_q)
            SYNC: begin
                if (sync_out) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d   = RELEASE;
                    cnt_d     = '0;
                    rst_out_d = rst_out_q & ~released_mask('0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SW_HOLD: begin
                if (cnt_q == SW_LAST) begin
                    state_d   = RELEASE;
                    cnt_d     = '0;
                    rst_out_d = rst_out_q & ~released_mask('0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == REL_LAST) begin
                    state_d     = RUN;
                    cnt_d       = '0;
                    ready_d     = 1'b1;
                    sw_ack_d    = sw_active_q;
                    sw_active_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    rst_out_d = rst_out_q & ~released_mask(cnt_q + CNT_W'(1));
                end
            end
            RUN: begin
                if (sw_req) begin
                    state_d     = SW_HOLD;
                    cnt_d       = '0;
                    rst_out_d   = '1;
                    ready_d     = 1'b0;
                    sw_active_d = 1'b1;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;
    assign sw_ack  = sw_ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default instance plus a minimal one
// (NUM_OUT=1, STAGGER=1, SYNC_STAGES=2, HOLD_CYCLES=1), checked every cycle
// against a timeline model expressed as edge counts since the last trigger.
module tb_reset_sequencer;

    localparam int SS  = 3;
    localparam int HC  = 16;
    localparam int NO  = 4;
    localparam int ST  = 2;
    localparam int SWH = 8;

    localparam int T0       = SS + HC + 1;
    localparam int TREADY   = T0 + (NO - 1) * ST + 1;
    localparam int SW_T0    = SWH + 1;
    localparam int SW_READY = SW_T0 + (NO - 1) * ST + 1;

    localparam int T0_MIN     = 2 + 1 + 1;
    localparam int TREADY_MIN = T0_MIN + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          swReq = 1'b0;
    logic          swReqMin = 1'b0;
    logic          swAck;
    logic          ready;
    logic [NO-1:0] rstOut;
    logic          swAckMin;
    logic          readyMin;
    logic [0:0]    rstOutMin;

    int compared   = 0;
    int mismatched = 0;
    int ackSeen    = 0;

    int edgesSinceRst = 0;
    int edgesSinceSw  = 0;
    bit swMode        = 1'b0;

    reset_sequencer #(
        .SYNC_STAGES(SS), .HOLD_CYCLES(HC), .NUM_OUT(NO),
        .STAGGER(ST), .SW_HOLD_CYCLES(SWH)
    ) dut (
        .clk(clk), .rst(rst), .sw_req(swReq), .sw_ack(swAck),
        .rst_out(rstOut), .ready(ready)
    );

    reset_sequencer #(
        .SYNC_STAGES(2), .HOLD_CYCLES(1), .NUM_OUT(1),
        .STAGGER(1), .SW_HOLD_CYCLES(8)
    ) dutMin (
        .clk(clk), .rst(rst), .sw_req(swReqMin), .sw_ack(swAckMin),
        .rst_out(rstOutMin), .ready(readyMin)
    );

    always #5 clk = ~clk;

    // Expected values derived purely from elapsed edges since the trigger.
    function automatic bit modelReady();
        if (swMode) return edgesSinceSw >= SW_READY;
        return edgesSinceRst >= TREADY;
    endfunction

    function automatic logic [NO-1:0] modelRstOut();
        logic [NO-1:0] v;
        for (int i = 0; i < NO; i++) begin
            if (swMode) v[i] = !(edgesSinceSw >= SW_T0 + i * ST);
            else        v[i] = !(edgesSinceRst >= T0 + i * ST);
        end
        return v;
    endfunction

    function automatic bit modelAck();
        return swMode && (edgesSinceSw == SW_READY);
    endfunction

    // Timeline model: rst restarts power-on, a request seen while ready restarts the software timeline.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edgesSinceRst <= 0;
            edgesSinceSw  <= 0;
            swMode        <= 1'b0;
        end else begin
            edgesSinceRst <= edgesSinceRst + 1;
            if (modelReady() && swReq) begin
                swMode       <= 1'b1;
                edgesSinceSw <= 0;
            end else begin
                edgesSinceSw <= edgesSinceSw + 1;
            end
        end
    end

    // Compare both instances against the model at the current instant.
    task automatic checkOutput(input string tag);
        logic [NO-1:0] expRst;
        logic          expReady;
        logic          expAck;
        logic [0:0]    expRstMin;
        logic          expReadyMin;
        expRst      = modelRstOut();
        expReady    = modelReady();
        expAck      = modelAck();
        expRstMin   = (edgesSinceRst < T0_MIN) ? 1'b1 : 1'b0;
        expReadyMin = (edgesSinceRst >= TREADY_MIN);

        compared++;
        assert (rstOut === expRst) else begin
            mismatched++;
            $error("[TB] FAIL %s rst_out: got %b want %b (edge %0d)", tag, rstOut, expRst, edgesSinceRst);
        end
        compared++;
        assert (ready === expReady) else begin
            mismatched++;
            $error("[TB] FAIL %s ready: got %b want %b (edge %0d)", tag, ready, expReady, edgesSinceRst);
        end
        compared++;
        assert (swAck === expAck) else begin
            mismatched++;
            $error("[TB] FAIL %s sw_ack: got %b want %b (edge %0d)", tag, swAck, expAck, edgesSinceRst);
        end
        compared++;
        assert (rstOutMin === expRstMin) else begin
            mismatched++;
            $error("[TB] FAIL %s min rst_out: got %b want %b (edge %0d)", tag, rstOutMin, expRstMin, edgesSinceRst);
        end
        compared++;
        assert (readyMin === expReadyMin) else begin
            mismatched++;
            $error("[TB] FAIL %s min ready: got %b want %b (edge %0d)", tag, readyMin, expReadyMin, edgesSinceRst);
        end
        compared++;
        assert (swAckMin === 1'b0) else begin
            mismatched++;
            $error("[TB] FAIL %s min sw_ack: got %b want 0", tag, swAckMin);
        end
    endtask

    // Run n cycles, checking at each falling edge. reqMode: 0 leave sw_req,
    // 1 drop it once sw_ack is seen, 2 randomize it every cycle.
    task automatic applyStimulus(input int n, input string tag, input int reqMode);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checkOutput(tag);
            if (swAck) ackSeen++;
            if (reqMode == 1 && swAck) swReq = 1'b0;
            else if (reqMode == 2) swReq = ($urandom_range(0, 3) == 0);
        end
    endtask

    // Raise rst between clock edges and check the outputs react without a clock.
    task automatic asyncResetPulse(input int offset, input int holdCycles, input string tag);
        @(posedge clk);
        #(offset);
        rst = 1'b1;
        #1;
        checkOutput(tag);
        applyStimulus(holdCycles, tag, 0);
        rst = 1'b0;
    endtask

    initial begin
        int ackCountExpected;
        int choice;

        // Reset state, before any clock edge
        #1 rst = 1'b1;
        #1 checkOutput("reset-async");
        applyStimulus(5, "reset-hold", 0);

        // Power-on timeline with defaults
        rst = 1'b0;
        applyStimulus(30, "poweron", 0);

        // Software reset with handshake
        swReq = 1'b1;
        ackSeen = 0;
        applyStimulus(25, "swreset", 1);
        ackCountExpected = 1;
        compared++;
        assert (ackSeen === ackCountExpected) else begin
            mismatched++;
            $error("[TB] FAIL swreset ack count: got %0d want %0d", ackSeen, ackCountExpected);
        end

        // Back-to-back requests: request held through two acknowledges
        swReq = 1'b1;
        ackSeen = 0;
        applyStimulus(40, "b2b", 0);
        ackCountExpected = 2;
        compared++;
        assert (ackSeen === ackCountExpected) else begin
            mismatched++;
            $error("[TB] FAIL b2b ack count: got %0d want %0d", ackSeen, ackCountExpected);
        end
        swReq = 1'b0;
        applyStimulus(20, "b2b-tail", 0);

        // Mid-sequence reset re-asserted asynchronously at edge 22
        rst = 1'b1;
        applyStimulus(3, "mid-rst", 0);
        rst = 1'b0;
        applyStimulus(21, "mid-run", 0);
        asyncResetPulse(2, 2, "mid-async");
        applyStimulus(30, "mid-restart", 0);

        // Early request during HOLD is serviced once RUN is reached
        rst = 1'b1;
        applyStimulus(2, "early-rst", 0);
        rst = 1'b0;
        applyStimulus(10, "early-hold", 0);
        swReq = 1'b1;
        ackSeen = 0;
        applyStimulus(50, "early", 1);
        ackCountExpected = 1;
        compared++;
        assert (ackSeen === ackCountExpected) else begin
            mismatched++;
            $error("[TB] FAIL early ack count: got %0d want %0d", ackSeen, ackCountExpected);
        end

        // Abandoned handshake: rst during SW_HOLD, request still pending afterwards
        swReq = 1'b1;
        ackSeen = 0;
        applyStimulus(4, "abandon-swhold", 0);
        asyncResetPulse(3, 2, "abandon-async");
        applyStimulus(60, "abandon-rerun", 1);
        ackCountExpected = 1;
        compared++;
        assert (ackSeen === ackCountExpected) else begin
            mismatched++;
            $error("[TB] FAIL abandon ack count: got %0d want %0d", ackSeen, ackCountExpected);
        end

        // Randomized mix of idle running, requests and async reset pulses
        for (int it = 0; it < 16; it++) begin
            choice = $urandom_range(0, 2);
            if (choice == 0) begin
                applyStimulus($urandom_range(5, 40), "rand-run", 2);
            end else if (choice == 1) begin
                asyncResetPulse($urandom_range(1, 4), $urandom_range(1, 3), "rand-rst");
                applyStimulus($urandom_range(1, 35), "rand-after-rst", 2);
            end else begin
                swReq = 1'b1;
                applyStimulus(30, "rand-sw", 1);
            end
        end
        swReq = 1'b0;
        applyStimulus(40, "final", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
